// File: rtl/cpu_image_loader.sv
`default_nettype none
// ============================================================================
// Module      : cpu_image_loader
// Description : Host-side driver for the 8-bit tiny-CPU pin interface.
//               Holds a 16x4 program image and a 16x4 data image. On start
//               it clears the CPU, streams both images in, sets the run
//               point, clocks the CPU for run_len ticks and captures the
//               CPU's {regval, pc} output after every tick.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock_i       host clock
//   reset_ni      asynchronous active-low reset
//   img_we_i      image write strobe (ignored while busy)
//   img_sel_i     0 = program image, 1 = data image
//   img_addr_i    image entry index
//   img_data_i    image entry value
//   start_i       one-cycle request to begin load+run (ignored while busy)
//   start_pc_i    run point, sampled with start
//   run_len_i     number of RUNPROG ticks, sampled with start
//   jump_en_i     driven on nibble bit3 during RUNPROG
//   cpu_io_in_o   to CPU io_in: {nibble[3:0], cmd[1:0], cpu_reset, cpu_clock}
//   cpu_io_out_i  from CPU io_out: {regval[3:0], pc[3:0]}
//   busy_o        sequence in progress
//   done_o        one-cycle completion pulse
//   pc_obs_o      last sampled CPU pc
//   reg_obs_o     last sampled CPU regval
// ============================================================================
module cpu_image_loader #(
  parameter int HALF_PERIOD = 1
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       img_we_i,
  input  logic       img_sel_i,
  input  logic [3:0] img_addr_i,
  input  logic [3:0] img_data_i,
  input  logic       start_i,
  input  logic [3:0] start_pc_i,
  input  logic [7:0] run_len_i,
  input  logic       jump_en_i,
  output logic [7:0] cpu_io_in_o,
  input  logic [7:0] cpu_io_out_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] pc_obs_o,
  output logic [3:0] reg_obs_o
);

  // A half period below one would make the CPU clock degenerate.
  localparam int HP   = (HALF_PERIOD < 1) ? 1 : HALF_PERIOD;
  localparam int PH_W = $clog2(2 * HP);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(2 * HP - 1);
  localparam logic [PH_W-1:0] HIGH_PH = PH_W'(HP);

  localparam logic [1:0] CMD_LOADPROG = 2'd0;
  localparam logic [1:0] CMD_LOADDATA = 2'd1;
  localparam logic [1:0] CMD_SETRUNPT = 2'd2;
  localparam logic [1:0] CMD_RUNPROG  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CLEAR   = 4'd1,
    S_SETPT_P = 4'd2,
    S_LOADP   = 4'd3,
    S_SETPT_D = 4'd4,
    S_LOADD   = 4'd5,
    S_SETPT_R = 4'd6,
    S_RUN     = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [7:0]        tick_q, tick_d;
  logic [3:0]        start_pc_q, start_pc_d;
  logic [7:0]        run_len_q, run_len_d;
  logic [7:0]        io_q, io_d;
  logic [3:0]        pc_obs_q, reg_obs_q;
  logic [3:0]        prog_img_q [16];
  logic [3:0]        data_img_q [16];

  logic [7:0]        last_tick;
  state_t            after_state;
  logic              img_wr_en;

  // Every state except IDLE and DONE is made of whole CPU clock ticks.
  function automatic logic is_tick_state(input state_t s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

  // --------------------------------------------------------------------------
  // Image storage: writable only while no sequence is running, so the
  // images stay frozen for the duration of a load+run.
  // --------------------------------------------------------------------------
  assign img_wr_en = img_we_i && !is_tick_state(state_q);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < 16; i++) begin
        prog_img_q[i] <= '0;
        data_img_q[i] <= '0;
      end
    end else if (img_wr_en) begin
      if (img_sel_i) begin
        data_img_q[img_addr_i] <= img_data_i;
      end else begin
        prog_img_q[img_addr_i] <= img_data_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-state tick count and successor.
  // --------------------------------------------------------------------------
  always_comb begin
    last_tick   = 8'd0;
    after_state = S_IDLE;
    case (state_q)
      S_CLEAR: begin
        last_tick   = 8'd1;
        after_state = S_SETPT_P;
      end
      S_SETPT_P: begin
        last_tick   = 8'd0;
        after_state = S_LOADP;
      end
      S_LOADP: begin
        last_tick   = 8'd15;
        after_state = S_SETPT_D;
      end
      S_SETPT_D: begin
        last_tick   = 8'd0;
        after_state = S_LOADD;
      end
      S_LOADD: begin
        last_tick   = 8'd15;
        after_state = S_SETPT_R;
      end
      S_SETPT_R: begin
        last_tick   = 8'd0;
        after_state = (run_len_q == 8'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        last_tick   = run_len_q - 8'd1;
        after_state = S_DONE;
      end
      default: begin
        last_tick   = 8'd0;
        after_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tick_d     = tick_q;
    start_pc_d = start_pc_q;
    run_len_d  = run_len_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_CLEAR;
          phase_d    = '0;
          tick_d     = 8'd0;
          start_pc_d = start_pc_i;
          run_len_d  = run_len_i;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        if (phase_q == LAST_PH) begin
          phase_d = '0;
          if (tick_q == last_tick) begin
            tick_d  = 8'd0;
            state_d = after_state;
          end else begin
            tick_d = tick_q + 8'd1;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // CPU pin drive. The pins are registered so the CPU clock is glitch free.
  // They are computed from the next state: the clock bit follows the phase
  // every cycle, while cmd/nibble/reset only update when a tick begins.
  // Outside a sequence the clock is parked low and the rest is held, which
  // keeps the CPU out of reset after its first run.
  // --------------------------------------------------------------------------
  always_comb begin
    io_d = io_q;
    if (is_tick_state(state_d)) begin
      io_d[0] = (phase_d >= HIGH_PH);
      if (phase_d == '0) begin
        io_d[1] = (state_d != S_CLEAR);
        case (state_d)
          S_SETPT_P, S_SETPT_D: begin
            io_d[3:2] = CMD_SETRUNPT;
            io_d[7:4] = 4'd0;
          end
          S_LOADP: begin
            io_d[3:2] = CMD_LOADPROG;
            io_d[7:4] = prog_img_q[tick_d[3:0]];
          end
          S_LOADD: begin
            io_d[3:2] = CMD_LOADDATA;
            io_d[7:4] = data_img_q[tick_d[3:0]];
          end
          S_SETPT_R: begin
            io_d[3:2] = CMD_SETRUNPT;
            io_d[7:4] = start_pc_d;
          end
          S_RUN: begin
            io_d[3:2] = CMD_RUNPROG;
            io_d[7:4] = {jump_en_i, 3'b000};
          end
          default: begin
            io_d[3:2] = CMD_LOADPROG;
            io_d[7:4] = 4'd0;
          end
        endcase
      end
    end else begin
      io_d[0] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      tick_q     <= 8'd0;
      start_pc_q <= 4'd0;
      run_len_q  <= 8'd0;
      io_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      start_pc_q <= start_pc_d;
      run_len_q  <= run_len_d;
      io_q       <= io_d;
    end
  end

  // CPU output is captured on the last host cycle of each tick, after the
  // CPU has had the whole high phase to respond to its rising clock edge.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_obs_q  <= 4'd0;
      reg_obs_q <= 4'd0;
    end else if (is_tick_state(state_q) && (phase_q == LAST_PH)) begin
      pc_obs_q  <= cpu_io_out_i[3:0];
      reg_obs_q <= cpu_io_out_i[7:4];
    end
  end

  assign cpu_io_in_o = io_q;
  assign busy_o      = is_tick_state(state_q);
  assign done_o      = (state_q == S_DONE);
  assign pc_obs_o    = pc_obs_q;
  assign reg_obs_o   = reg_obs_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_image_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_image_loader
// Description : Directed self-checking bench for cpu_image_loader with a
//               small behavioural tiny-CPU attached to the pin interface.
//               CPU opcodes used here: 0 NOP, 1 LOAD, 2 ADD, 3 JUMPTOIF.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_image_loader;

  logic       clock_i;
  logic       reset_ni;
  logic       img_we_i;
  logic       img_sel_i;
  logic [3:0] img_addr_i;
  logic [3:0] img_data_i;
  logic       start_i;
  logic [3:0] start_pc_i;
  logic [7:0] run_len_i;
  logic       jump_en_i;
  logic [7:0] cpu_io_in;
  logic [7:0] cpu_io_out;
  logic       busy_o;
  logic       done_o;
  logic [3:0] pc_obs_o;
  logic [3:0] reg_obs_o;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] io_log [0:2047];
  logic       busy_c1;
  int         dcyc;

  cpu_image_loader #(.HALF_PERIOD(1)) dut (
    .clock_i     (clock_i),
    .reset_ni    (reset_ni),
    .img_we_i    (img_we_i),
    .img_sel_i   (img_sel_i),
    .img_addr_i  (img_addr_i),
    .img_data_i  (img_data_i),
    .start_i     (start_i),
    .start_pc_i  (start_pc_i),
    .run_len_i   (run_len_i),
    .jump_en_i   (jump_en_i),
    .cpu_io_in_o (cpu_io_in),
    .cpu_io_out_i(cpu_io_out),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pc_obs_o    (pc_obs_o),
    .reg_obs_o   (reg_obs_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // ---------------- behavioural tiny CPU ----------------
  logic [3:0] m_pc, m_reg, m_addr;
  logic [3:0] m_prog [16];
  logic [3:0] m_data [16];

  initial begin
    m_pc = 4'd0; m_reg = 4'd0; m_addr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      m_prog[i] = 4'd0;
      m_data[i] = 4'd0;
    end
  end

  always @(posedge cpu_io_in[0]) begin
    if (!cpu_io_in[1]) begin
      m_pc <= 4'd0; m_reg <= 4'd0; m_addr <= 4'd0;
    end else begin
      case (cpu_io_in[3:2])
        2'd0: begin m_prog[m_addr] <= cpu_io_in[7:4]; m_addr <= m_addr + 4'd1; end
        2'd1: begin m_data[m_addr] <= cpu_io_in[7:4]; m_addr <= m_addr + 4'd1; end
        2'd2: begin m_addr <= 4'd0; m_pc <= cpu_io_in[7:4]; end
        default: begin
          case (m_prog[m_pc])
            4'd1: begin m_reg <= m_data[m_pc]; m_pc <= m_pc + 4'd1; end
            4'd2: begin m_reg <= m_reg + m_data[m_pc]; m_pc <= m_pc + 4'd1; end
            4'd3: m_pc <= cpu_io_in[7] ? m_data[m_pc] : m_pc + 4'd1;
            default: m_pc <= m_pc + 4'd1;
          endcase
        end
      endcase
    end
  end

  assign cpu_io_out = {m_reg, m_pc};

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock_i); #1;
  endtask

  task automatic write_img(input logic sel, input logic [3:0] addr, input logic [3:0] data);
    img_we_i = 1'b1; img_sel_i = sel; img_addr_i = addr; img_data_i = data;
    step();
    img_we_i = 1'b0;
  endtask

  // Issues start in the current cycle (cycle 0), logs cpu_io_in for each
  // following cycle and returns the cycle number of the done pulse (-1 on
  // timeout). At cycle inj a start plus a program-image write is injected.
  task automatic run_seq(input logic [3:0] pc, input logic [7:0] len,
                         input int inj, output int dc);
    start_pc_i = pc; run_len_i = len; start_i = 1'b1;
    step();
    start_i = 1'b0; img_we_i = 1'b0;
    busy_c1 = busy_o;
    dc = -1;
    for (int c = 1; c < 2000; c++) begin
      io_log[c] = cpu_io_in;
      if (done_o) begin
        dc = c;
        break;
      end
      if (c == inj) begin
        start_i = 1'b1; img_we_i = 1'b1; img_sel_i = 1'b0;
        img_addr_i = 4'd0; img_data_i = 4'hF;
      end
      step();
      start_i = 1'b0; img_we_i = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic saw_done;
    saw_done = 1'b0;
    reset_ni = 1'b0;
    img_we_i = 0; img_sel_i = 0; img_addr_i = 0; img_data_i = 0;
    start_i = 0; start_pc_i = 0; run_len_i = 0; jump_en_i = 0;
    repeat (3) step();
    @(negedge clock_i);
    reset_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_o) saw_done = 1'b1;
    end
    n_cmp++; if (cpu_io_in !== 8'h00) begin n_bad++; $display("FAIL reset_io got %h want 00", cpu_io_in); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", saw_done); end
    n_cmp++; if (pc_obs_o !== 4'd0) begin n_bad++; $display("FAIL reset_pc got %h want 0", pc_obs_o); end
    n_cmp++; if (reg_obs_o !== 4'd0) begin n_bad++; $display("FAIL reset_reg got %h want 0", reg_obs_o); end
  endtask

  task automatic test_load_timing();
    logic [3:0] pv;
    for (int k = 0; k < 16; k++) begin
      pv = 4'(15 - k);
      write_img(1'b0, 4'(k), pv);
    end
    run_seq(4'hA, 8'd0, -1, dcyc);
    n_cmp++; if (busy_c1 !== 1'b1) begin n_bad++; $display("FAIL busy_cycle1 got %b want 1", busy_c1); end
    n_cmp++; if (dcyc != 75) begin n_bad++; $display("FAIL done_cycle got %0d want 75", dcyc); end
    n_cmp++; if (io_log[1][1:0] !== 2'b00) begin n_bad++; $display("FAIL clear_low got %b want 00", io_log[1][1:0]); end
    n_cmp++; if (io_log[2][1:0] !== 2'b01) begin n_bad++; $display("FAIL clear_high got %b want 01", io_log[2][1:0]); end
    for (int k = 0; k < 16; k++) begin
      pv = 4'(15 - k);
      n_cmp++;
      if (io_log[7 + 2*k] !== {pv, 4'b0010}) begin
        n_bad++; $display("FAIL loadp_low k=%0d got %h want %h", k, io_log[7 + 2*k], {pv, 4'b0010});
      end
      n_cmp++;
      if (io_log[8 + 2*k] !== {pv, 4'b0011}) begin
        n_bad++; $display("FAIL loadp_high k=%0d got %h want %h", k, io_log[8 + 2*k], {pv, 4'b0011});
      end
    end
    n_cmp++; if (io_log[73] !== 8'hAA) begin n_bad++; $display("FAIL setpt_r_low got %h want AA", io_log[73]); end
    n_cmp++; if (io_log[74] !== 8'hAB) begin n_bad++; $display("FAIL setpt_r_high got %h want AB", io_log[74]); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL busy_at_done got %b want 0", busy_o); end
    step();
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL done_width got %b want 0", done_o); end
    n_cmp++; if (cpu_io_in[1:0] !== 2'b10) begin n_bad++; $display("FAIL idle_pins got %b want 10", cpu_io_in[1:0]); end
  endtask

  task automatic test_add();
    for (int k = 0; k < 16; k++) begin
      write_img(1'b0, 4'(k), (k == 0) ? 4'd1 : 4'd0);
      write_img(1'b1, 4'(k), (k == 0) ? 4'd3 : ((k == 1) ? 4'd4 : 4'd0));
    end
    // ADD at address 1 is written in the same cycle as start.
    img_we_i = 1'b1; img_sel_i = 1'b0; img_addr_i = 4'd1; img_data_i = 4'd2;
    run_seq(4'd0, 8'd2, -1, dcyc);
    n_cmp++; if (dcyc != 79) begin n_bad++; $display("FAIL add_done_cycle got %0d want 79", dcyc); end
    n_cmp++; if (io_log[9] !== 8'h22) begin n_bad++; $display("FAIL same_cycle_write got %h want 22", io_log[9]); end
    n_cmp++; if (reg_obs_o !== 4'd7) begin n_bad++; $display("FAIL add_reg got %h want 7", reg_obs_o); end
    n_cmp++; if (pc_obs_o !== 4'd2) begin n_bad++; $display("FAIL add_pc got %h want 2", pc_obs_o); end
    step();
  endtask

  task automatic test_jump();
    write_img(1'b0, 4'd0, 4'd3);
    write_img(1'b0, 4'd1, 4'd0);
    write_img(1'b1, 4'd0, 4'd9);
    jump_en_i = 1'b1;
    run_seq(4'd0, 8'd1, -1, dcyc);
    n_cmp++; if (dcyc != 77) begin n_bad++; $display("FAIL jump_done_cycle got %0d want 77", dcyc); end
    n_cmp++; if (io_log[75] !== 8'h8E) begin n_bad++; $display("FAIL run_low got %h want 8E", io_log[75]); end
    n_cmp++; if (io_log[76] !== 8'h8F) begin n_bad++; $display("FAIL run_high got %h want 8F", io_log[76]); end
    n_cmp++; if (pc_obs_o !== 4'd9) begin n_bad++; $display("FAIL jump_taken_pc got %h want 9", pc_obs_o); end
    step();
    jump_en_i = 1'b0;
    run_seq(4'd0, 8'd1, -1, dcyc);
    n_cmp++; if (io_log[75] !== 8'h0E) begin n_bad++; $display("FAIL run_nojump got %h want 0E", io_log[75]); end
    n_cmp++; if (pc_obs_o !== 4'd1) begin n_bad++; $display("FAIL jump_not_taken_pc got %h want 1", pc_obs_o); end
    step();
  endtask

  task automatic test_back_to_back();
    // Start and program write injected at cycle 45, inside LOADD.
    run_seq(4'd0, 8'd0, 45, dcyc);
    n_cmp++; if (dcyc != 75) begin n_bad++; $display("FAIL busy_start_done got %0d want 75", dcyc); end
    step();
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL no_restart got %b want 0", busy_o); end
    step();
    run_seq(4'd0, 8'd0, -1, dcyc);
    n_cmp++; if (io_log[7] !== 8'h32) begin n_bad++; $display("FAIL image_frozen got %h want 32", io_log[7]); end
    step();
  endtask

  task automatic test_reset_mid();
    start_pc_i = 4'd0; run_len_i = 8'd0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (16) step();
    // Cycle 17: LOADP tick 5, clock low, prog[5] is 0.
    n_cmp++; if (cpu_io_in !== 8'h02) begin n_bad++; $display("FAIL pre_reset_io got %h want 02", cpu_io_in); end
    #2 reset_ni = 1'b0;
    #1;
    n_cmp++; if (cpu_io_in !== 8'h00) begin n_bad++; $display("FAIL midreset_io got %h want 00", cpu_io_in); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy_o); end
    @(negedge clock_i);
    reset_ni = 1'b1;
    step();
    run_seq(4'd0, 8'd0, -1, dcyc);
    n_cmp++; if (dcyc != 75) begin n_bad++; $display("FAIL post_reset_done got %0d want 75", dcyc); end
    n_cmp++; if (io_log[7] !== 8'h02) begin n_bad++; $display("FAIL image_cleared got %h want 02", io_log[7]); end
  endtask

  initial begin
    test_reset();
    test_load_timing();
    test_add();
    test_jump();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
